muldiv_sequencer: RTL and testbench

Iterative multiply/divide unit and sequencer for the RV32M operations decoded by the control unit (ALUOP 01xxx). It sits beside the single-cycle ALU in the execute stage. It accepts one operation, stalls the pipeline while it iterates, and returns a 32-bit result with a one-cycle DONE pulse.

---
 rtl/muldiv_sequencer.sv | 146 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to compute products in a single combinational FIX step.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       aluop,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flush,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     a_mag_q, b_mag_q, result_q;
  logic [2:0]           op_q;
  logic                 neg_a_q, neg_b_q, busy_q, done_q;

  logic                 accept, a_signed, b_signed, neg_a, neg_b;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, trial, diff;
  logic                 ge;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod, prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s, fix_result;

  // Reset gates the accept so STALL stays low while held in reset.
  assign accept = reset_n & start & ~flush & (state_q == StIdle) & (aluop[4:3] == 2'b01);
  assign stall  = accept | busy_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    unique case (aluop[2:0])
      3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
    neg_a = a_signed & operand1[WIDTH-1];
    neg_b = b_signed & operand2[WIDTH-1];
    a_mag = neg_a ? -operand1 : operand1;
    b_mag = neg_b ? -operand2 : operand2;
  end

  // Multiply keeps the multiplier in the low half; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge       = trial >= {1'b0, b_mag_q};
    diff     = trial - {1'b0, b_mag_q};
    div_next = {(ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
  end

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod = {{WIDTH{1'b0}}, a_mag_q} * {{WIDTH{1'b0}}, b_mag_q};
`else
    prod = acc_q;
`endif
    prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
    // Divide by zero: all-ones quotient; the remainder already equals the dividend.
    quo_s  = (b_mag_q == '0) ? '1 :
             ((neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_s  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    unique case (op_q)
      3'b000:                 fix_result = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_result = quo_s;
      default:                fix_result = rem_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
          state_d = aluop[2] ? StCalc : StFix;
`else
          state_d = StCalc;
`endif
        end
      end
      StCalc: begin
        if (flush)                 state_d = StIdle;
        else if (cnt_q == LastCnt) state_d = StFix;
      end
      StFix:   state_d = flush ? StIdle : StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == StCalc) || (state_d == StFix);
      done_q  <= (state_d == StDone);
      if (accept) begin
        a_mag_q <= a_mag;
        b_mag_q <= b_mag;
        neg_a_q <= neg_a;
        neg_b_q <= neg_b;
        op_q    <= aluop[2:0];
        cnt_q   <= '0;
        acc_q   <= {{WIDTH{1'b0}}, (aluop[2] ? a_mag : b_mag)};
      end else if (state_q == StCalc) begin
        acc_q <= op_q[2] ? div_next : mul_next;
        cnt_q <= cnt_q + CntW'(1);
      end
      if (state_q == StFix && !flush) result_q <= fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (WIDTH=32).
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  aluop;
  logic [31:0] operand1, operand2;
  logic        flush;
  logic [31:0] result;
  logic        busy, stall, done;

  int n_cmp = 0;
  int n_bad = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .aluop    (aluop),
    .operand1 (operand1),
    .operand2 (operand2),
    .flush    (flush),
    .result   (result),
    .busy     (busy),
    .stall    (stall),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one op, optionally pokes START mid-run, checks latency and result.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input int poke);
    int   n;
    logic stall_ok;
    start = 1'b1; aluop = op; operand1 = a; operand2 = b;
    #1;
    check({tag, " stall_accept"}, {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    stall_ok = 1'b1;
    while (!done && n < 100) begin
      if (!stall || !busy) stall_ok = 1'b0;
      if (n == poke) begin
        start = 1'b1; aluop = 5'b01000; operand1 = 32'd5; operand2 = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " stall_high"}, {31'd0, stall_ok}, 32'd1);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " stall_in_done"}, {31'd0, stall}, 32'd0);
    check({tag, " result"}, result, exp_res);
    @(negedge clk);
    check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic seen;
    // Reset with a valid request held: nothing may be accepted.
    reset_n = 1'b0; start = 1'b1; aluop = 5'b01000;
    operand1 = 32'd3; operand2 = 32'd4; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst stall", {31'd0, stall}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst result", result, 32'd0);
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    run_op("mul", 5'b01000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat, -1);
    run_op("mulh", 5'b01001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MulLat, -1);
    run_op("mulhsu", 5'b01010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat, -1);
    run_op("mulhu", 5'b01011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat, -1);
    run_op("div", 5'b01100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DivLat, -1);
    run_op("rem", 5'b01110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DivLat, -1);
    run_op("divu", 5'b01101, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, DivLat, -1);
    // 100 / 7 with a START poked during CALC that must be ignored.
    run_op("divu_poke", 5'b01101, 32'd100, 32'd7, 32'd14, DivLat, 3);
    run_op("remu", 5'b01111, 32'd100, 32'd7, 32'd2, DivLat, -1);
    run_op("div0", 5'b01100, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, DivLat, -1);
    run_op("rem0", 5'b01110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, DivLat, -1);

    // Non-M opcode: ignored, no stall.
    start = 1'b1; aluop = 5'b00011;
    #1;
    check("nonm stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("nonm busy", {31'd0, busy}, 32'd0);

    // FLUSH on CALC cycle 10.
    start = 1'b1; aluop = 5'b01101; operand1 = 32'd100; operand2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy_after", {31'd0, busy}, 32'd0);
    check("flush stall_after", {31'd0, stall}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("flush no_done", {31'd0, seen}, 32'd0);
    check("flush result_held", result, 32'h0000_1234);

    run_op("ovf_rem", 5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DivLat, -1);
    run_op("ovf_div", 5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DivLat, -1);

    // Async reset on CALC cycle 5.
    start = 1'b1; aluop = 5'b01101; operand1 = 32'd100; operand2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst result", result, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b1; aluop = 5'b00000;
    #1;
    check("postrst stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (done || busy || stall) seen = 1'b1;
      @(negedge clk);
    end
    check("postrst quiet", {31'd0, seen}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
